mem_burst_ctrl: RTL and testbench

Cache-side initiator for the external memory interface. It moves one cache block of BLOCK_WORDS words between the cache and memory, either as a refill (memory to cache) or a writeback (cache to memory). It issues one word per memory access and advances only when memory signals a completed access. It sits between the cache FSM and the memory model or memory port, and drives the memory's write-enable, address and write-data inputs.

---
 rtl/mem_burst_ctrl.sv | 113 +++++++++++
 tb/tb_mem_burst_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl
// Moves one cache block of BLOCK_WORDS words between the cache and external
// memory. A refill copies memory to the cache; a writeback copies the cache
// to memory. One word moves per memory access, and the controller advances
// only on a cycle where memory reports a completed access.
//
// Ports
//   clk            clock, rising edge
//   arstn          synchronous active-low reset
//   i_start_read   request a block refill (accepted in IDLE only)
//   i_start_write  request a block writeback (accepted in IDLE only, wins over read)
//   i_addr         block byte address, sampled when a request is accepted
//   i_wr_word      cache word at o_word_idx, used as write data
//   o_word_idx     current word index within the block
//   o_rd_word      refill word (mirror of i_mem_rdata)
//   o_rd_valid     o_rd_word is to be written into the cache this cycle
//   o_busy         transfer in progress
//   o_done         one-cycle completion pulse
//   o_mem_we       memory write enable, high only in a completing write cycle
//   o_mem_addr     memory byte address, 0 when not transferring
//   o_mem_wdata    memory write data (mirror of i_wr_word)
//   i_mem_rdata    memory read data
//   i_mem_access   memory access completes this cycle
module mem_burst_ctrl #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 64,
    parameter int unsigned BLOCK_WORDS = 16
) (
    input  logic                           clk,
    input  logic                           arstn,
    input  logic                           i_start_read,
    input  logic                           i_start_write,
    input  logic [ADDR_WIDTH-1:0]          i_addr,
    input  logic [DATA_WIDTH-1:0]          i_wr_word,
    output logic [$clog2(BLOCK_WORDS)-1:0] o_word_idx,
    output logic [DATA_WIDTH-1:0]          o_rd_word,
    output logic                           o_rd_valid,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_mem_we,
    output logic [ADDR_WIDTH-1:0]          o_mem_addr,
    output logic [DATA_WIDTH-1:0]          o_mem_wdata,
    input  logic [DATA_WIDTH-1:0]          i_mem_rdata,
    input  logic                           i_mem_access
);

    localparam int unsigned IDX_W = $clog2(BLOCK_WORDS);
    // Byte offset bits covered by one block (word index plus 2 byte bits).
    localparam int unsigned OFF_W = IDX_W + 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                     state;
    logic [IDX_W-1:0]           idx;
    // Only the block-aligned upper address bits are kept; the low bits are
    // always zero after acceptance.
    logic [ADDR_WIDTH-OFF_W-1:0] base_hi;
    logic                       xfer;

    always_ff @(posedge clk) begin
        if (!arstn) begin
            state   <= IDLE;
            idx     <= '0;
            base_hi <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start_write || i_start_read) begin
                        state   <= i_start_write ? WRITE : READ;
                        base_hi <= i_addr[ADDR_WIDTH-1:OFF_W];
                        idx     <= '0;
                    end
                end
                READ, WRITE: begin
                    if (i_mem_access) begin
                        // Power-of-two block: the increment wraps the last
                        // index back to 0 as the FSM enters DONE.
                        idx <= idx + 1'b1;
                        if (idx == LAST_IDX) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        xfer        = (state == READ) || (state == WRITE);
        o_word_idx  = idx;
        o_busy      = (state != IDLE);
        o_done      = (state == DONE);
        o_rd_word   = i_mem_rdata;
        o_mem_wdata = i_wr_word;
        o_rd_valid  = (state == READ) && i_mem_access;
        o_mem_we    = (state == WRITE) && i_mem_access;
        // base + idx*4 reduces to concatenation since base is block-aligned.
        o_mem_addr  = xfer ? {base_hi, idx, 2'b00} : '0;
    end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
module tb_mem_burst_ctrl;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        i_start_read = 1'b0;
    logic        i_start_write = 1'b0;
    logic [63:0] i_addr = '0;
    logic [31:0] i_wr_word;
    logic [3:0]  o_word_idx;
    logic [31:0] o_rd_word;
    logic        o_rd_valid;
    logic        o_busy;
    logic        o_done;
    logic        o_mem_we;
    logic [63:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;
    logic        i_mem_access = 1'b0;

    int pass_cnt = 0;
    int total_cnt = 0;

    mem_burst_ctrl #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (64),
        .BLOCK_WORDS(16)
    ) dut (
        .clk          (clk),
        .arstn        (arstn),
        .i_start_read (i_start_read),
        .i_start_write(i_start_write),
        .i_addr       (i_addr),
        .i_wr_word    (i_wr_word),
        .o_word_idx   (o_word_idx),
        .o_rd_word    (o_rd_word),
        .o_rd_valid   (o_rd_valid),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_rdata  (i_mem_rdata),
        .i_mem_access (i_mem_access)
    );

    always #5 clk = ~clk;

    // Memory returns 0xA000_0000 + word-in-block; cache offers 0xB0 + index.
    assign i_mem_rdata = 32'hA000_0000 + 32'(o_mem_addr[5:2]);
    assign i_wr_word   = 32'hB0 + 32'(o_word_idx);

    // Memory write model and event monitors.
    logic [31:0] wmem [logic [63:0]];
    int wcount = 0;
    int done_cnt = 0;
    always @(posedge clk) begin
        if (o_mem_we) begin
            wmem[o_mem_addr] = o_mem_wdata;
            wcount++;
        end
        if (o_done) done_cnt++;
    end

    typedef struct {
        logic        sr;
        logic        sw;
        logic        acc;
        logic [63:0] addr;
        logic        busy;
        logic        done;
        logic        we;
        logic        rv;
        logic [63:0] maddr;
        logic [3:0]  idx;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_refill(input logic [63:0] addr, input int gap, input bit hold);
        logic [63:0] base;
        int spurious;
        base = addr & ~64'h3F;
        spurious = 0;
        i_start_read = 1'b1;
        i_addr = addr;
        tick();
        i_start_read = 1'b0;
        i_addr = 64'hDEAD_BEEF_0000_0FC4;
        for (int k = 0; k < 16; k++) begin
            for (int g = 0; g < gap; g++) begin
                i_mem_access = 1'b0;
                @(negedge clk);
                if (o_rd_valid || !o_busy) spurious++;
                tick();
            end
            i_mem_access = 1'b1;
            @(negedge clk);
            check($sformatf("rd_valid[%0d]", k), 64'(o_rd_valid), 64'd1);
            check($sformatf("rd_addr[%0d]", k), o_mem_addr, base + 64'(4 * k));
            check($sformatf("rd_idx[%0d]", k), 64'(o_word_idx), 64'(k));
            check($sformatf("rd_word[%0d]", k), 64'(o_rd_word), 64'(32'hA000_0000 + k));
            tick();
            if (!hold) i_mem_access = 1'b0;
        end
        @(negedge clk);
        check("rd_done", 64'(o_done), 64'd1);
        check("rd_done_busy", 64'(o_busy), 64'd1);
        check("rd_done_valid", 64'(o_rd_valid), 64'd0);
        check("rd_done_idx", 64'(o_word_idx), 64'd0);
        check("rd_done_addr", o_mem_addr, 64'd0);
        tick();
        i_mem_access = 1'b0;
        @(negedge clk);
        check("rd_after_busy", 64'(o_busy), 64'd0);
        check("rd_after_done", 64'(o_done), 64'd0);
        check("rd_gap_spurious", 64'(spurious), 64'd0);
    endtask

    task automatic do_write(input logic [63:0] addr, input int gap, input int nwords);
        logic [63:0] base;
        int spurious;
        base = addr & ~64'h3F;
        spurious = 0;
        i_start_write = 1'b1;
        i_addr = addr;
        tick();
        i_start_write = 1'b0;
        for (int k = 0; k < nwords; k++) begin
            for (int g = 0; g < gap; g++) begin
                i_mem_access = 1'b0;
                @(negedge clk);
                if (o_mem_we) spurious++;
                tick();
            end
            i_mem_access = 1'b1;
            @(negedge clk);
            check($sformatf("wr_we[%0d]", k), 64'(o_mem_we), 64'd1);
            check($sformatf("wr_addr[%0d]", k), o_mem_addr, base + 64'(4 * k));
            check($sformatf("wr_wdata[%0d]", k), 64'(o_mem_wdata), 64'(32'hB0 + k));
            tick();
            i_mem_access = 1'b0;
        end
        check("wr_gap_spurious", 64'(spurious), 64'd0);
    endtask

    task automatic check_block(input string name, input logic [63:0] base, input int nwords);
        int bad;
        bad = 0;
        for (int k = 0; k < nwords; k++) begin
            if (!wmem.exists(base + 64'(4 * k))) bad++;
            else if (wmem[base + 64'(4 * k)] !== 32'hB0 + 32'(k)) bad++;
        end
        check(name, 64'(bad), 64'd0);
    endtask

    initial begin
        int w0;
        int d0;

        //            sr sw acc addr              busy done we rv maddr          idx
        vecs[0] = '{1'b0, 1'b0, 1'b1, 64'h0,    1'b0, 1'b0, 1'b0, 1'b0, 64'h0,    4'd0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 64'h0,    1'b0, 1'b0, 1'b0, 1'b0, 64'h0,    4'd0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 64'h2044, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,    4'd0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 64'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 64'h2040, 4'd0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 64'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 64'h2040, 4'd0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 64'h5000, 1'b1, 1'b0, 1'b1, 1'b0, 64'h2044, 4'd1};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 64'h9000, 1'b1, 1'b0, 1'b0, 1'b0, 64'h2048, 4'd2};

        // Reset with access held high.
        arstn = 1'b0;
        i_mem_access = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_done", 64'(o_done), 64'd0);
        check("rst_we", 64'(o_mem_we), 64'd0);
        check("rst_valid", 64'(o_rd_valid), 64'd0);
        check("rst_addr", o_mem_addr, 64'd0);
        check("rst_idx", 64'(o_word_idx), 64'd0);
        tick();
        arstn = 1'b1;

        // Idle, then simultaneous start (write wins), then starts while busy.
        w0 = wcount;
        d0 = done_cnt;
        foreach (vecs[i]) begin
            i_start_read  = vecs[i].sr;
            i_start_write = vecs[i].sw;
            i_mem_access  = vecs[i].acc;
            i_addr        = vecs[i].addr;
            @(negedge clk);
            check($sformatf("vec%0d_busy", i), 64'(o_busy), 64'(vecs[i].busy));
            check($sformatf("vec%0d_done", i), 64'(o_done), 64'(vecs[i].done));
            check($sformatf("vec%0d_we", i), 64'(o_mem_we), 64'(vecs[i].we));
            check($sformatf("vec%0d_valid", i), 64'(o_rd_valid), 64'(vecs[i].rv));
            check($sformatf("vec%0d_addr", i), o_mem_addr, vecs[i].maddr);
            check($sformatf("vec%0d_idx", i), 64'(o_word_idx), 64'(vecs[i].idx));
            tick();
        end
        i_start_read = 1'b0;
        i_start_write = 1'b0;
        for (int k = 2; k < 16; k++) begin
            i_mem_access = 1'b1;
            @(negedge clk);
            check($sformatf("both_we[%0d]", k), 64'(o_mem_we), 64'd1);
            check($sformatf("both_addr[%0d]", k), o_mem_addr, 64'h2040 + 64'(4 * k));
            tick();
        end
        i_mem_access = 1'b0;
        i_start_read = 1'b1;
        i_addr = 64'h7000;
        @(negedge clk);
        check("both_done", 64'(o_done), 64'd1);
        tick();
        i_start_read = 1'b0;
        @(negedge clk);
        check("both_idle_after_done", 64'(o_busy), 64'd0);
        tick();
        tick();
        @(negedge clk);
        check("both_no_read_started", 64'(o_busy), 64'd0);
        check("both_done_once", 64'(done_cnt - d0), 64'd1);
        check("both_write_count", 64'(wcount - w0), 64'd16);
        check_block("both_mem", 64'h2040, 16);

        // Refill with slow memory (one completion every 128 cycles).
        do_refill(64'h1044, 127, 1'b0);

        // Writeback with an access every third cycle.
        w0 = wcount;
        do_write(64'h2000, 2, 16);
        @(negedge clk);
        check("wb_done", 64'(o_done), 64'd1);
        tick();
        @(negedge clk);
        check("wb_idle", 64'(o_busy), 64'd0);
        check("wb_write_count", 64'(wcount - w0), 64'd16);
        check_block("wb_mem", 64'h2000, 16);

        // Back-to-back refill with access held high.
        do_refill(64'h4000, 0, 1'b1);

        // Reset in the middle of a writeback after five words.
        w0 = wcount;
        do_write(64'h3000, 0, 5);
        arstn = 1'b0;
        tick();
        i_mem_access = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 64'(o_busy), 64'd0);
        check("mid_rst_done", 64'(o_done), 64'd0);
        check("mid_rst_we", 64'(o_mem_we), 64'd0);
        check("mid_rst_valid", 64'(o_rd_valid), 64'd0);
        check("mid_rst_addr", o_mem_addr, 64'd0);
        check("mid_rst_idx", 64'(o_word_idx), 64'd0);
        tick();
        arstn = 1'b1;
        i_mem_access = 1'b0;
        tick();
        check("mid_rst_write_count", 64'(wcount - w0), 64'd5);
        check_block("mid_rst_mem", 64'h3000, 5);
        check("mid_rst_word5_absent", 64'(wmem.exists(64'h3014)), 64'd0);
        do_refill(64'h5008, 1, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
